// File: rtl/zigzag_rle_streamer_if.sv
// Block-in / symbol-out bus of the zig-zag run-length streamer.
// The slave view belongs to the streamer. The master view belongs to the
// zig-zag buffer and entropy coder side.
interface zigzag_rle_streamer_if #(
  parameter int COEF_WIDTH = 10,
  parameter int NUM_COEF   = 64
);
  logic                           block_valid;
  logic                           block_ready;
  logic [COEF_WIDTH*NUM_COEF-1:0] block_data;
  logic                           sym_valid;
  logic                           sym_ready;
  logic [3:0]                     sym_run;
  logic [COEF_WIDTH-1:0]          sym_level;
  logic                           sym_is_dc;
  logic                           sym_is_zrl;
  logic                           sym_is_eob;
  logic                           block_done;

  modport slave (
    input  block_valid, block_data, sym_ready,
    output block_ready, sym_valid, sym_run, sym_level,
           sym_is_dc, sym_is_zrl, sym_is_eob, block_done
  );

  modport master (
    output block_valid, block_data, sym_ready,
    input  block_ready, sym_valid, sym_run, sym_level,
           sym_is_dc, sym_is_zrl, sym_is_eob, block_done
  );
endinterface

// File: rtl/zigzag_rle_streamer.sv
// Turns one zig-zag ordered block of 64 quantized coefficients into a stream
// of JPEG run/level symbols: DC, AC(run, level), ZRL and EOB.
// Every symbol output and block_done is driven straight from a flop.
module zigzag_rle_streamer #(
  parameter int COEF_WIDTH = 10,
  parameter int NUM_COEF   = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  zigzag_rle_streamer_if.slave bus
);
  localparam int BLK_W = COEF_WIDTH * NUM_COEF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DC,
    S_SCAN,
    S_ZRL,
    S_AC,
    S_EOB
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            idx_q, idx_d;
  logic [5:0]            run_q, run_d;
  logic [5:0]            run_less16;
  logic [BLK_W-1:0]      shadow_q;
  logic [COEF_WIDTH-1:0] coef [NUM_COEF];
  logic [COEF_WIDTH-1:0] cur_coef;
  logic                  capture;

  logic                  vld_q, vld_d;
  logic [3:0]            srun_q, srun_d;
  logic [COEF_WIDTH-1:0] lvl_q, lvl_d;
  logic                  dc_q, dc_d;
  logic                  zrl_q, zrl_d;
  logic                  eob_q, eob_d;
  logic                  done_q, done_d;

  assign bus.block_ready = (state_q == S_IDLE);
  assign bus.sym_valid   = vld_q;
  assign bus.sym_run     = srun_q;
  assign bus.sym_level   = lvl_q;
  assign bus.sym_is_dc   = dc_q;
  assign bus.sym_is_zrl  = zrl_q;
  assign bus.sym_is_eob  = eob_q;
  assign bus.block_done  = done_q;

  assign run_less16 = run_q - 6'd16;
  assign cur_coef   = coef[idx_q];

  // View the captured block as an array of coefficients in zig-zag order.
  always_comb begin
    for (int unsigned k = 0; k < NUM_COEF; k++) begin
      coef[k] = shadow_q[k*COEF_WIDTH +: COEF_WIDTH];
    end
  end

  // Next state, scan counters, and the symbol that will be presented next cycle.
  // Symbol fields are computed one cycle early so they can leave from flops;
  // entering a symbol state loads its fields, and a handshake either loads
  // the following symbol or clears the outputs.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    run_d   = run_q;
    capture = 1'b0;
    vld_d   = vld_q;
    srun_d  = srun_q;
    lvl_d   = lvl_q;
    dc_d    = dc_q;
    zrl_d   = zrl_q;
    eob_d   = eob_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.block_valid) begin
          capture = 1'b1;
          state_d = S_DC;
          idx_d   = '0;
          run_d   = '0;
          vld_d   = 1'b1;
          dc_d    = 1'b1;
          zrl_d   = 1'b0;
          eob_d   = 1'b0;
          srun_d  = '0;
          lvl_d   = bus.block_data[COEF_WIDTH-1:0];
        end
      end

      S_DC: begin
        if (bus.sym_ready) begin
          state_d = S_SCAN;
          idx_d   = 6'd1;
          vld_d   = 1'b0;
          dc_d    = 1'b0;
          srun_d  = '0;
          lvl_d   = '0;
        end
      end

      S_SCAN: begin
        if (cur_coef == '0) begin
          if (idx_q == 6'd63) begin
            state_d = S_EOB;
            vld_d   = 1'b1;
            eob_d   = 1'b1;
            srun_d  = '0;
            lvl_d   = '0;
          end else begin
            run_d = run_q + 6'd1;
            idx_d = idx_q + 6'd1;
          end
        end else if (run_q >= 6'd16) begin
          state_d = S_ZRL;
          vld_d   = 1'b1;
          zrl_d   = 1'b1;
          srun_d  = 4'd15;
          lvl_d   = '0;
        end else begin
          state_d = S_AC;
          vld_d   = 1'b1;
          srun_d  = run_q[3:0];
          lvl_d   = cur_coef;
        end
      end

      S_ZRL: begin
        if (bus.sym_ready) begin
          run_d = run_less16;
          if (run_less16 < 6'd16) begin
            state_d = S_AC;
            zrl_d   = 1'b0;
            srun_d  = run_less16[3:0];
            lvl_d   = cur_coef;
          end
        end
      end

      S_AC: begin
        if (bus.sym_ready) begin
          run_d  = '0;
          vld_d  = 1'b0;
          srun_d = '0;
          lvl_d  = '0;
          if (idx_q == 6'd63) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_SCAN;
            idx_d   = idx_q + 6'd1;
          end
        end
      end

      S_EOB: begin
        if (bus.sym_ready) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          vld_d   = 1'b0;
          eob_d   = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
        dc_d    = 1'b0;
        zrl_d   = 1'b0;
        eob_d   = 1'b0;
      end
    endcase
  end

  // State, counters, captured block and registered symbol outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      run_q    <= '0;
      shadow_q <= '0;
      vld_q    <= 1'b0;
      srun_q   <= '0;
      lvl_q    <= '0;
      dc_q     <= 1'b0;
      zrl_q    <= 1'b0;
      eob_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      run_q   <= run_d;
      vld_q   <= vld_d;
      srun_q  <= srun_d;
      lvl_q   <= lvl_d;
      dc_q    <= dc_d;
      zrl_q   <= zrl_d;
      eob_q   <= eob_d;
      done_q  <= done_d;
      if (capture) begin
        shadow_q <= bus.block_data;
      end
    end
  end
endmodule

// File: tb/tb_zigzag_rle_streamer.sv
// Self-checking bench for zigzag_rle_streamer. Expected symbol streams come
// from a run-length model computed directly from the coefficient values.
module tb_zigzag_rle_streamer;
  localparam logic [1:0] K_DC  = 2'd0;
  localparam logic [1:0] K_AC  = 2'd1;
  localparam logic [1:0] K_ZRL = 2'd2;
  localparam logic [1:0] K_EOB = 2'd3;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] run;
    logic [9:0] lvl;
  } sym_t;

  logic clock = 1'b0;
  logic reset_n;
  int   cyc = 0;

  zigzag_rle_streamer_if #(.COEF_WIDTH(10), .NUM_COEF(64)) bus ();

  zigzag_rle_streamer #(.COEF_WIDTH(10), .NUM_COEF(64)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  sym_t obs_q[$];
  sym_t exp_q[$];
  int   cap_cyc, dc_cyc, done_cyc, carry_cyc;
  bit   carry = 1'b0;
  bit   timeout;
  logic done_rdy;
  int   stall_bad, rdy_bad, flag_bad;
  int   n_pass = 0;
  int   n_total = 0;

  function automatic logic [639:0] rand_bits();
    logic [639:0] b;
    for (int i = 0; i < 20; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  function automatic logic [639:0] rand_block(input int unsigned dens);
    logic [639:0] b;
    logic [9:0]   v;
    b = '0;
    for (int k = 0; k < 64; k++) begin
      if ($urandom_range(99) < dens) begin
        v = 10'($urandom);
        if (v == 10'd0) v = 10'h200;
        b[k*10 +: 10] = v;
      end
    end
    return b;
  endfunction

  function automatic sym_t cur_sym();
    sym_t s;
    s.kind = bus.sym_is_dc ? K_DC : bus.sym_is_zrl ? K_ZRL : bus.sym_is_eob ? K_EOB : K_AC;
    s.run  = bus.sym_run;
    s.lvl  = bus.sym_level;
    return s;
  endfunction

  // Reference: DC raw, then for every nonzero AC coefficient up to the last
  // nonzero one, emit ZRLs for each full 16 zeros and an AC with the rest;
  // an EOB closes the block when the final coefficient is zero.
  task automatic build_model(input logic [639:0] blk);
    logic [9:0] c [64];
    int   last, run;
    sym_t s;
    exp_q.delete();
    for (int k = 0; k < 64; k++) c[k] = blk[k*10 +: 10];
    s.kind = K_DC; s.run = 4'd0; s.lvl = c[0];
    exp_q.push_back(s);
    last = 0;
    for (int k = 1; k < 64; k++) if (c[k] != 10'd0) last = k;
    run = 0;
    for (int k = 1; k <= last; k++) begin
      if (c[k] == 10'd0) run++;
      else begin
        while (run >= 16) begin
          s.kind = K_ZRL; s.run = 4'd15; s.lvl = 10'd0;
          exp_q.push_back(s);
          run -= 16;
        end
        s.kind = K_AC; s.run = 4'(run); s.lvl = c[k];
        exp_q.push_back(s);
        run = 0;
      end
    end
    if (last != 63) begin
      s.kind = K_EOB; s.run = 4'd0; s.lvl = 10'd0;
      exp_q.push_back(s);
    end
  endtask

  // Presents one block, drives sym_ready with the given duty and records every
  // transferred symbol plus timing and protocol observations. Entered and left
  // at a falling edge.
  task automatic stream_block(input logic [639:0] data, input int unsigned pct,
                              input bit chain, input logic [639:0] next_data);
    int unsigned guard;
    bit   stalled, first;
    sym_t held, now;
    obs_q.delete();
    stall_bad = 0; rdy_bad = 0; flag_bad = 0; timeout = 0;
    dc_cyc = -1; done_cyc = -1; stalled = 0; held = '0;
    if (carry) begin
      cap_cyc = carry_cyc;
      carry   = 1'b0;
    end else begin
      bus.block_data  = data;
      bus.block_valid = 1'b1;
      guard = 0;
      while (bus.block_ready !== 1'b1 && guard < 200) begin
        @(negedge clock);
        guard++;
      end
      if (guard >= 200) begin
        timeout = 1;
        bus.block_valid = 1'b0;
        return;
      end
      cap_cyc = cyc;
    end
    first = 1; guard = 0;
    forever begin
      @(negedge clock);
      guard++;
      if (first) begin
        bus.block_data  = chain ? next_data : rand_bits();
        bus.block_valid = chain;
        first = 0;
      end
      now = cur_sym();
      if (stalled && (bus.sym_valid !== 1'b1 || now !== held)) stall_bad++;
      stalled = 0;
      if (bus.sym_valid && (int'(bus.sym_is_dc) + int'(bus.sym_is_zrl) + int'(bus.sym_is_eob)) > 1)
        flag_bad++;
      if (bus.sym_valid && bus.sym_is_dc && dc_cyc < 0) dc_cyc = cyc;
      if (bus.block_done === 1'b1) begin
        done_cyc = cyc;
        done_rdy = bus.block_ready;
        if (bus.block_valid && bus.block_ready) begin
          carry     = 1'b1;
          carry_cyc = cyc;
        end
        break;
      end
      if (bus.block_ready !== 1'b0) rdy_bad++;
      if (guard >= 3000) begin
        timeout = 1;
        break;
      end
      bus.sym_ready = ($urandom_range(99) < pct);
      if (bus.sym_valid) begin
        if (bus.sym_ready) obs_q.push_back(now);
        else begin
          stalled = 1;
          held    = now;
        end
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (bus.block_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.block_ready); else n_pass++;
    n_total++; if (bus.sym_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.sym_valid); else n_pass++;
    n_total++; if (bus.block_done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.block_done); else n_pass++;
    n_total++;
    if ({bus.sym_run, bus.sym_level, bus.sym_is_dc, bus.sym_is_zrl, bus.sym_is_eob} !== 17'd0)
      $display("FAIL rst_fields: got %h want 0", {bus.sym_run, bus.sym_level, bus.sym_is_dc, bus.sym_is_zrl, bus.sym_is_eob});
    else n_pass++;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_all_zero();
    sym_t got;
    build_model('0);
    stream_block('0, 100, 0, '0);
    n_total++; if (timeout) $display("FAIL zero_timeout: got 1 want 0"); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL zero_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_total++; if (got !== exp_q[i]) $display("FAIL zero_sym[%0d]: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
    n_total++; if (done_cyc - cap_cyc != 66) $display("FAIL zero_latency: got %0d want 66", done_cyc - cap_cyc); else n_pass++;
    n_total++; if (dc_cyc - cap_cyc != 1) $display("FAIL zero_dc_latency: got %0d want 1", dc_cyc - cap_cyc); else n_pass++;
    n_total++; if (rdy_bad != 0) $display("FAIL zero_ready_low: got %0d want 0", rdy_bad); else n_pass++;
    n_total++; if (done_rdy !== 1'b1) $display("FAIL zero_done_ready: got %b want 1", done_rdy); else n_pass++;
    @(negedge clock);
    n_total++; if (bus.block_done !== 1'b0) $display("FAIL zero_done_pulse: got %b want 0", bus.block_done); else n_pass++;
  endtask

  task automatic test_mixed();
    logic [639:0] blk;
    sym_t got;
    blk = '0;
    blk[9:0]   = 10'h3FB;
    blk[19:10] = 10'd3;
    blk[59:50] = 10'h3FF;
    build_model(blk);
    stream_block(blk, 100, 0, '0);
    n_total++; if (timeout) $display("FAIL mixed_timeout: got 1 want 0"); else n_pass++;
    n_total++; if (obs_q.size() != 4) $display("FAIL mixed_len: got %0d want 4", obs_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_total++; if (got !== exp_q[i]) $display("FAIL mixed_sym[%0d]: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
    got = (obs_q.size() > 2) ? obs_q[2] : '1;
    n_total++; if (got !== {K_AC, 4'd3, 10'h3FF}) $display("FAIL mixed_ac3: got %h want %h", got, {K_AC, 4'd3, 10'h3FF}); else n_pass++;
  endtask

  task automatic test_zrl_tail();
    logic [639:0] blk;
    sym_t got;
    int   nzrl;
    blk = '0;
    blk[639:630] = 10'd7;
    build_model(blk);
    stream_block(blk, 100, 0, '0);
    nzrl = 0;
    foreach (obs_q[i]) if (obs_q[i].kind == K_ZRL) nzrl++;
    n_total++; if (timeout) $display("FAIL tail_timeout: got 1 want 0"); else n_pass++;
    n_total++; if (nzrl != 3) $display("FAIL tail_zrl_count: got %0d want 3", nzrl); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL tail_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_total++; if (got !== exp_q[i]) $display("FAIL tail_sym[%0d]: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [639:0] blk;
    sym_t got;
    blk = '0;
    blk[639:630] = 10'd7;
    build_model(blk);
    stream_block(blk, 30, 0, '0);
    n_total++; if (timeout) $display("FAIL bp_timeout: got 1 want 0"); else n_pass++;
    n_total++; if (stall_bad != 0) $display("FAIL bp_stall_stable: got %0d want 0", stall_bad); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL bp_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_total++; if (got !== exp_q[i]) $display("FAIL bp_sym[%0d]: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_random();
    logic [639:0] blk;
    sym_t got;
    int unsigned dens [4] = '{3, 10, 40, 90};
    for (int b = 0; b < 8; b++) begin
      blk = rand_block(dens[b % 4]);
      if (b == 5) blk[639:630] = 10'h200;
      build_model(blk);
      stream_block(blk, $urandom_range(100, 25), 0, '0);
      n_total++; if (timeout) $display("FAIL rnd%0d_timeout: got 1 want 0", b); else n_pass++;
      n_total++; if (stall_bad != 0 || flag_bad != 0) $display("FAIL rnd%0d_protocol: got stall=%0d flags=%0d want 0", b, stall_bad, flag_bad); else n_pass++;
      n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL rnd%0d_len: got %0d want %0d", b, obs_q.size(), exp_q.size()); else n_pass++;
      foreach (exp_q[i]) begin
        got = (i < obs_q.size()) ? obs_q[i] : '1;
        n_total++; if (got !== exp_q[i]) $display("FAIL rnd%0d_sym[%0d]: got %h want %h", b, i, got, exp_q[i]); else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [639:0] a, b;
    sym_t got;
    int   a_done;
    a = rand_block(20);
    b = rand_block(20);
    build_model(a);
    stream_block(a, 100, 1, b);
    a_done = done_cyc;
    n_total++; if (!carry) $display("FAIL b2b_capture_in_done: got 0 want 1"); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_a_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_total++; if (got !== exp_q[i]) $display("FAIL b2b_a_sym[%0d]: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
    build_model(b);
    stream_block(b, 100, 0, '0);
    n_total++; if (dc_cyc != a_done + 1) $display("FAIL b2b_dc_next: got %0d want %0d", dc_cyc, a_done + 1); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL b2b_b_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_total++; if (got !== exp_q[i]) $display("FAIL b2b_b_sym[%0d]: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    logic [639:0] blk;
    sym_t got;
    int unsigned guard;
    int   done_seen;
    blk = '0;
    blk[639:630] = 10'($urandom_range(511, 1));
    bus.block_data  = blk;
    bus.block_valid = 1'b1;
    bus.sym_ready   = 1'b1;
    @(negedge clock);
    bus.block_valid = 1'b0;
    guard = 0;
    while (bus.sym_is_zrl !== 1'b1 && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    n_total++; if (guard >= 200) $display("FAIL mid_reach_zrl: got timeout want zrl"); else n_pass++;
    #2 reset_n = 1'b0;
    #1;
    n_total++;
    if ({bus.sym_valid, bus.sym_is_zrl, bus.block_ready, bus.sym_run, bus.sym_level} !== {1'b0, 1'b0, 1'b1, 4'd0, 10'd0})
      $display("FAIL mid_async_reset: got valid=%b zrl=%b ready=%b run=%0d lvl=%h want 0 0 1 0 0",
               bus.sym_valid, bus.sym_is_zrl, bus.block_ready, bus.sym_run, bus.sym_level);
    else n_pass++;
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.block_done !== 1'b0) done_seen++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (bus.block_done !== 1'b0) done_seen++;
    end
    n_total++; if (done_seen != 0) $display("FAIL mid_no_done: got %0d want 0", done_seen); else n_pass++;
    blk = rand_block(15);
    build_model(blk);
    stream_block(blk, 100, 0, '0);
    n_total++; if (dc_cyc - cap_cyc != 1) $display("FAIL mid_dc_latency: got %0d want 1", dc_cyc - cap_cyc); else n_pass++;
    n_total++; if (obs_q.size() != exp_q.size()) $display("FAIL mid_len: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    foreach (exp_q[i]) begin
      got = (i < obs_q.size()) ? obs_q[i] : '1;
      n_total++; if (got !== exp_q[i]) $display("FAIL mid_sym[%0d]: got %h want %h", i, got, exp_q[i]); else n_pass++;
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    bus.block_valid = 1'b0;
    bus.block_data  = '0;
    bus.sym_ready   = 1'b0;
    test_reset();
    test_all_zero();
    test_mixed();
    test_zrl_tail();
    test_backpressure();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/zigzag_rle_streamer.md
# zigzag_rle_streamer

Consumes one 640-bit zig-zag-ordered block of 64 quantized 10-bit coefficients, as produced by the zig-zag buffer stage. Emits it as a stream of JPEG run/level symbols: DC, AC (run, level), ZRL and EOB, one symbol per handshake. It sits between the zig-zag buffer and the Huffman/entropy coder and is the read side of the 640-bit block interface.

## Interface
- `COEF_WIDTH`, 10: width of each signed coefficient.
- `NUM_COEF`, 64: coefficients per block. Fixed at 64; other values are unsupported.
- `clock`  in  1  sole clock; all logic is rising-edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `block_valid`  in  1  `block_data` holds a complete block.
- `block_ready`  out  1  the streamer can accept a block. High only in IDLE.
- `block_data`  in  640  coefficient k (zig-zag index) is `[10k+9:10k]`, two's complement; k=0 is DC.
- `sym_valid`  out  1  symbol outputs are valid.
- `sym_ready`  in  1  the downstream coder accepts the symbol.
- `sym_run`  out  4  zero run preceding the level. 0 for DC and EOB; 15 for ZRL.
- `sym_level`  out  10  signed level. 0 for ZRL and EOB.
- `sym_is_dc`, `sym_is_zrl`, `sym_is_eob`  out  1 each  symbol type flags. At most one is high; none high means an AC symbol.
- `block_done`  out  1  one-cycle pulse when a block has been fully emitted.

## Operation
- The block is captured into an internal 640-bit shadow register when `block_valid && block_ready`. Upstream may change `block_data` after that.
- Internal state:
  - `idx` (6 bits): current zig-zag index.
  - `run` (6 bits): pending zero count, range 0..62.
- FSM states:
  - IDLE:
    - `block_ready`=1.
    - On capture: `idx`←0, `run`←0, go to DC.
  - DC:
    - `sym_valid`=1, `sym_is_dc`=1, `sym_level`=coef[0], `sym_run`=0.
    - On handshake: `idx`←1, go to SCAN.
  - SCAN (no output; examines coef[`idx`], one coefficient per cycle):
    - If zero and `idx`<63: `run`++, `idx`++.
    - If zero and `idx`==63: go to EOB.
    - If nonzero: go to ZRL if `run`≥16, else go to AC.
  - ZRL:
    - `sym_valid`=1, `sym_is_zrl`=1, `sym_run`=15, `sym_level`=0.
    - On handshake: `run`←`run`−16. Stay in ZRL if the new `run`≥16, else go to AC.
  - AC:
    - `sym_valid`=1, `sym_run`=`run[3:0]`, `sym_level`=coef[`idx`].
    - On handshake: `run`←0.
    - If `idx`==63: go to IDLE and pulse `block_done`.
    - Otherwise: `idx`++, go to SCAN.
  - EOB:
    - `sym_valid`=1, `sym_is_eob`=1, `sym_run`=0, `sym_level`=0.
    - On handshake: go to IDLE and pulse `block_done`.
- EOB is emitted only when a trailing run of zeros ends the block. If coef[63] is nonzero, no EOB is emitted.
- The DC level is emitted raw. Differential DC coding happens downstream.
- ZRL is emitted only when a nonzero AC coefficient follows. Trailing zeros never produce ZRL.

## Timing
- Reset values:
  - State=IDLE, so `block_ready`=1.
  - `sym_valid`=0, `block_done`=0.
  - All symbol fields, `idx`, `run` and the shadow register are 0.
- Output registers: all symbol outputs and `block_done` come directly from flops. `block_ready` is decoded from state only.
- Input handshake: a capture at edge N puts DC on `sym_valid` in cycle N+1 (latency 1).
- Output handshake:
  - A symbol transfers on an edge where `sym_valid && sym_ready`.
  - While `sym_valid && !sym_ready`, all symbol outputs hold stable.
  - `sym_valid` never drops without a handshake.
- SCAN spends exactly one cycle per zero coefficient examined, plus one cycle on the terminating coefficient.
- `block_done` is high for exactly one cycle, the cycle after the final handshake, coincident with `block_ready` returning to 1. A new block can be captured in that same cycle.
- `block_valid` outside IDLE is ignored; the held block stays pending upstream.
- Reset asserted mid-block: immediate return to IDLE with reset values. The partial block is discarded and no `block_done` is issued.
- Throughput: with `sym_ready` held at 1, an all-zero block takes 66 cycles from capture to `block_done`.

## Test plan
- All-zero block, `sym_ready`=1:
  - Symbols: DC (level 0), then EOB.
  - `block_done` 66 cycles after capture.
  - `block_ready` low during that time.
- coef[0]=−5 (10'h3FB), coef[1]=3, coef[5]=−1, rest 0:
  - DC −5.
  - AC run0 lvl3.
  - AC run3 lvl 10'h3FF.
  - EOB.
- Only coef[63]=7 nonzero (62 zeros between):
  - DC 0.
  - ZRL, ZRL, ZRL.
  - AC run14 lvl7.
  - No EOB, then `block_done`.
- Backpressure: random `sym_ready` (about 30% duty) on the previous case. The symbol sequence is identical, and outputs hold stable on every stalled cycle.
- Back-to-back blocks with `block_valid` held high:
  - The second block is captured in the `block_done` cycle.
  - Its DC appears on the next cycle.
  - No symbols are lost or duplicated.
- Reset pulse in the middle of the ZRL run:
  - Outputs return to reset values asynchronously.
  - The next block streams correctly from DC.
